// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: byte-enabled data memory, synchronous load
// path and the MEM/WB register feeding writeback.
module mem_stage #(
    parameter int DATA_WIDTH          = 32,
    parameter int DATA_MEM_DEPTH      = 1024,
    parameter int DATA_MEM_ADDR_WIDTH = $clog2(DATA_MEM_DEPTH),
    parameter int ADDR_WIDTH          = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_mem_write_i,
    input  logic [2:0]            ex_funct3_i,
    input  logic [DATA_WIDTH-1:0] ex_alu_result_i,
    input  logic [DATA_WIDTH-1:0] ex_store_data_i,
    input  logic [DATA_WIDTH-1:0] ex_pc_plus4_i,
    input  logic [ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic                  ex_reg_write_i,
    input  logic [1:0]            ex_wb_sel_i,
    output logic                  wb_valid_o,
    output logic                  wb_reg_write_o,
    output logic [ADDR_WIDTH-1:0] wb_rd_addr_o,
    output logic [1:0]            wb_sel_o,
    output logic [DATA_WIDTH-1:0] wb_alu_result_o,
    output logic [DATA_WIDTH-1:0] wb_pc_plus4_o,
    output logic [DATA_WIDTH-1:0] wb_mem_data_o,
    output logic                  wb_fault_o
);

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_NONE = 2'd3;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_LWU = 3'b110;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // Load formatting: select the addressed byte/half and sign- or zero-extend.
    function automatic logic [DATA_WIDTH-1:0] fmt_load(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            lane,
        input logic [2:0]            funct3
    );
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        case (lane)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            default: byte_s = word[31:24];
        endcase
        half_s = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            FUNCT3_LB:  fmt_load = {{24{byte_s[7]}}, byte_s};
            FUNCT3_LBU: fmt_load = {24'd0, byte_s};
            FUNCT3_LH:  fmt_load = {{16{half_s[15]}}, half_s};
            FUNCT3_LHU: fmt_load = {16'd0, half_s};
            default:    fmt_load = word;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] mem [DATA_MEM_DEPTH];

    logic [DATA_MEM_ADDR_WIDTH-1:0] word_idx;
    logic [1:0]                     lane;
    logic                           access;
    logic                           misalign;
    logic                           illegal;
    logic                           fault;
    logic                           we;
    logic [3:0]                     be;
    logic [DATA_WIDTH-1:0]          st_data;

    logic [DATA_WIDTH-1:0] raw_word_p1;
    logic [1:0]            lane_p1;
    logic [2:0]            funct3_p1;
    logic                  vld_ld_p1;

    assign word_idx = ex_alu_result_i[DATA_MEM_ADDR_WIDTH+1:2];
    assign lane     = ex_alu_result_i[1:0];
    assign access   = ex_valid_i & (ex_mem_read_i | ex_mem_write_i);

    always_comb begin
        misalign = 1'b0;
        illegal  = 1'b0;
        if (ex_mem_write_i) begin
            case (ex_funct3_i)
                FUNCT3_SB: misalign = 1'b0;
                FUNCT3_SH: misalign = lane[0];
                FUNCT3_SW: misalign = (lane != 2'd0);
                default:   illegal  = 1'b1;
            endcase
        end else begin
            case (ex_funct3_i)
                FUNCT3_LB, FUNCT3_LBU: misalign = 1'b0;
                FUNCT3_LH, FUNCT3_LHU: misalign = lane[0];
                FUNCT3_LW, FUNCT3_LWU: misalign = (lane != 2'd0);
                default:               illegal  = 1'b1;
            endcase
        end
        fault = access & (misalign | illegal);
    end

    always_comb begin
        be      = 4'b1111;
        st_data = ex_store_data_i;
        case (ex_funct3_i[1:0])
            2'b00: begin
                be      = 4'b0001 << lane;
                st_data = {4{ex_store_data_i[7:0]}};
            end
            2'b01: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{ex_store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Reset, stall and flush all veto the write so a killed store never lands.
    assign we = ex_valid_i & ex_mem_write_i & ~fault & ~stall_i & ~flush_i & ~rst;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    // ---- EX/MEM -> MEM/WB boundary: raw load word (data only, no reset) ----
    always_ff @(posedge clk) begin
        if (!stall_i) begin
            raw_word_p1 <= mem[word_idx];
            lane_p1     <= lane;
            funct3_p1   <= ex_funct3_i;
        end
    end

    // ---- EX/MEM -> MEM/WB boundary: writeback fields and control ----
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_o      <= 1'b0;
            wb_reg_write_o  <= 1'b0;
            wb_fault_o      <= 1'b0;
            wb_sel_o        <= WB_NONE;
            wb_rd_addr_o    <= '0;
            wb_alu_result_o <= '0;
            wb_pc_plus4_o   <= '0;
            vld_ld_p1       <= 1'b0;
        end else if (flush_i) begin
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            wb_fault_o     <= 1'b0;
            wb_sel_o       <= WB_NONE;
            vld_ld_p1      <= 1'b0;
        end else if (!stall_i) begin
            wb_valid_o      <= ex_valid_i;
            wb_reg_write_o  <= ex_valid_i & ex_reg_write_i & ~fault;
            wb_fault_o      <= fault;
            wb_sel_o        <= ex_wb_sel_i;
            wb_rd_addr_o    <= ex_rd_addr_i;
            wb_alu_result_o <= ex_alu_result_i;
            wb_pc_plus4_o   <= ex_pc_plus4_i;
            vld_ld_p1       <= ex_valid_i & ex_mem_read_i & ~fault;
        end
    end

    assign wb_mem_data_o = vld_ld_p1 ? fmt_load(raw_word_p1, lane_p1, funct3_p1) : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, extended loads, faults, stall/flush,
// address wrap and mid-store reset, each with hand-computed expectations.
module tb_mem_stage;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_NONE = 2'd3;

    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i;
    logic        ex_valid_i, ex_mem_read_i, ex_mem_write_i, ex_reg_write_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_alu_result_i, ex_store_data_i, ex_pc_plus4_i;
    logic [4:0]  ex_rd_addr_i;
    logic [1:0]  ex_wb_sel_i;
    logic        wb_valid_o, wb_reg_write_o, wb_fault_o;
    logic [4:0]  wb_rd_addr_o;
    logic [1:0]  wb_sel_o;
    logic [31:0] wb_alu_result_o, wb_pc_plus4_o, wb_mem_data_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_mem_read_i(ex_mem_read_i),
        .ex_mem_write_i(ex_mem_write_i), .ex_funct3_i(ex_funct3_i),
        .ex_alu_result_i(ex_alu_result_i), .ex_store_data_i(ex_store_data_i),
        .ex_pc_plus4_i(ex_pc_plus4_i), .ex_rd_addr_i(ex_rd_addr_i),
        .ex_reg_write_i(ex_reg_write_i), .ex_wb_sel_i(ex_wb_sel_i),
        .wb_valid_o(wb_valid_o), .wb_reg_write_o(wb_reg_write_o),
        .wb_rd_addr_o(wb_rd_addr_o), .wb_sel_o(wb_sel_o),
        .wb_alu_result_o(wb_alu_result_o), .wb_pc_plus4_o(wb_pc_plus4_o),
        .wb_mem_data_o(wb_mem_data_o), .wb_fault_o(wb_fault_o)
    );

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rda,
                         input logic rw, input logic [1:0] sel);
        ex_valid_i      = v;
        ex_mem_read_i   = rd;
        ex_mem_write_i  = wr;
        ex_funct3_i     = f3;
        ex_alu_result_i = addr;
        ex_store_data_i = sd;
        ex_rd_addr_i    = rda;
        ex_reg_write_i  = rw;
        ex_wb_sel_i     = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd);
        drive(1'b1, 1'b0, 1'b1, f3, addr, sd, 5'd0, 1'b0, WB_NONE);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rda);
        drive(1'b1, 1'b1, 1'b0, f3, addr, 32'd0, rda, 1'b1, WB_MEM);
    endtask

    task automatic test_reset;
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; ex_pc_plus4_i = 32'h0000_0004;
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0123, 32'd0, 5'd3, 1'b1, WB_ALU);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0123, 32'd0, 5'd3, 1'b1, WB_ALU);
        checks++;
        if ({wb_valid_o, wb_reg_write_o, wb_fault_o, wb_rd_addr_o} !== 8'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b%b%b rd=%0d exp=000 rd=0", wb_valid_o, wb_reg_write_o, wb_fault_o, wb_rd_addr_o);
        end
        checks++;
        if (wb_sel_o !== WB_NONE) begin
            failures++; $display("FAIL reset_sel got=%0d exp=%0d", wb_sel_o, WB_NONE);
        end
        checks++;
        if ({wb_alu_result_o, wb_pc_plus4_o, wb_mem_data_o} !== 96'd0) begin
            failures++;
            $display("FAIL reset_data got alu=%h pc4=%h mem=%h exp all 0", wb_alu_result_o, wb_pc_plus4_o, wb_mem_data_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_sw_lw;
        st(3'b010, 32'h100, 32'hDEAD_BEEF);
        ld(3'b010, 32'h100, 5'd5);
        checks++;
        if (wb_mem_data_o !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL sw_lw_data got=%h exp=deadbeef", wb_mem_data_o);
        end
        checks++;
        if ({wb_valid_o, wb_reg_write_o, wb_fault_o, wb_rd_addr_o, wb_sel_o} !== {3'b110, 5'd5, WB_MEM}) begin
            failures++;
            $display("FAIL sw_lw_ctrl got v=%b rw=%b f=%b rd=%0d sel=%0d exp v=1 rw=1 f=0 rd=5 sel=1",
                     wb_valid_o, wb_reg_write_o, wb_fault_o, wb_rd_addr_o, wb_sel_o);
        end
    endtask

    task automatic test_byte;
        st(3'b010, 32'h100, 32'h1122_3344);
        st(3'b000, 32'h103, 32'h0000_0080);
        ld(3'b000, 32'h103, 5'd6);
        checks++;
        if (wb_mem_data_o !== 32'hFFFF_FF80) begin
            failures++; $display("FAIL lb_sext got=%h exp=ffffff80", wb_mem_data_o);
        end
        ld(3'b100, 32'h103, 5'd6);
        checks++;
        if (wb_mem_data_o !== 32'h0000_0080) begin
            failures++; $display("FAIL lbu_zext got=%h exp=00000080", wb_mem_data_o);
        end
        ld(3'b010, 32'h100, 5'd6);
        checks++;
        if (wb_mem_data_o !== 32'h8022_3344) begin
            failures++; $display("FAIL sb_merge got=%h exp=80223344", wb_mem_data_o);
        end
        ld(3'b000, 32'h101, 5'd6);
        checks++;
        if (wb_mem_data_o !== 32'h0000_0033) begin
            failures++; $display("FAIL lb_lane1 got=%h exp=00000033", wb_mem_data_o);
        end
    endtask

    task automatic test_half;
        st(3'b010, 32'h200, 32'h0000_1234);
        st(3'b001, 32'h202, 32'h0000_BEEF);
        ld(3'b001, 32'h202, 5'd7);
        checks++;
        if (wb_mem_data_o !== 32'hFFFF_BEEF) begin
            failures++; $display("FAIL lh_sext got=%h exp=ffffbeef", wb_mem_data_o);
        end
        ld(3'b101, 32'h202, 5'd7);
        checks++;
        if (wb_mem_data_o !== 32'h0000_BEEF) begin
            failures++; $display("FAIL lhu_zext got=%h exp=0000beef", wb_mem_data_o);
        end
        ld(3'b001, 32'h201, 5'd7);
        checks++;
        if ({wb_fault_o, wb_reg_write_o, wb_valid_o, wb_mem_data_o} !== {3'b101, 32'd0}) begin
            failures++;
            $display("FAIL lh_misalign got f=%b rw=%b v=%b d=%h exp f=1 rw=0 v=1 d=0",
                     wb_fault_o, wb_reg_write_o, wb_valid_o, wb_mem_data_o);
        end
        st(3'b001, 32'h201, 32'h0000_5555);
        checks++;
        if (wb_fault_o !== 1'b1) begin
            failures++; $display("FAIL sh_misalign_fault got=%b exp=1", wb_fault_o);
        end
        st(3'b011, 32'h200, 32'h7777_7777);
        checks++;
        if (wb_fault_o !== 1'b1) begin
            failures++; $display("FAIL store_illegal_fault got=%b exp=1", wb_fault_o);
        end
        ld(3'b010, 32'h200, 5'd7);
        checks++;
        if (wb_mem_data_o !== 32'hBEEF_1234 || wb_fault_o !== 1'b0) begin
            failures++; $display("FAIL fault_no_write got=%h f=%b exp=beef1234 f=0", wb_mem_data_o, wb_fault_o);
        end
        ld(3'b111, 32'h200, 5'd7);
        checks++;
        if ({wb_fault_o, wb_reg_write_o, wb_mem_data_o} !== {2'b10, 32'd0}) begin
            failures++; $display("FAIL load_illegal got f=%b rw=%b d=%h exp f=1 rw=0 d=0", wb_fault_o, wb_reg_write_o, wb_mem_data_o);
        end
        ld(3'b110, 32'h200, 5'd7);
        checks++;
        if (wb_mem_data_o !== 32'hBEEF_1234 || wb_fault_o !== 1'b0) begin
            failures++; $display("FAIL lwu_as_lw got=%h f=%b exp=beef1234 f=0", wb_mem_data_o, wb_fault_o);
        end
    endtask

    task automatic test_stall_flush;
        st(3'b010, 32'h0, 32'h0BAD_F00D);
        ld(3'b010, 32'h0, 5'd7);
        stall_i = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0, 32'hAAAA_5555, 5'd9, 1'b0, WB_NONE);
        checks++;
        if ({wb_valid_o, wb_reg_write_o, wb_rd_addr_o, wb_sel_o, wb_mem_data_o} !== {2'b11, 5'd7, WB_MEM, 32'h0BAD_F00D}) begin
            failures++;
            $display("FAIL stall_hold got v=%b rw=%b rd=%0d sel=%0d d=%h exp v=1 rw=1 rd=7 sel=1 d=0badf00d",
                     wb_valid_o, wb_reg_write_o, wb_rd_addr_o, wb_sel_o, wb_mem_data_o);
        end
        stall_i = 1'b0;
        st(3'b010, 32'h100, 32'h5A5A_5A5A);
        drive(1'b0, 1'b0, 1'b1, 3'b010, 32'h100, 32'hFFFF_FFFF, 5'd0, 1'b1, WB_ALU);
        checks++;
        if (wb_valid_o !== 1'b0 || wb_reg_write_o !== 1'b0) begin
            failures++; $display("FAIL invalid_entry got v=%b rw=%b exp v=0 rw=0", wb_valid_o, wb_reg_write_o);
        end
        ld(3'b010, 32'h100, 5'd8);
        checks++;
        if (wb_mem_data_o !== 32'h5A5A_5A5A) begin
            failures++; $display("FAIL invalid_no_write got=%h exp=5a5a5a5a", wb_mem_data_o);
        end
        ld(3'b010, 32'h0, 5'd7);
        checks++;
        if (wb_mem_data_o !== 32'h0BAD_F00D) begin
            failures++; $display("FAIL stall_no_write got=%h exp=0badf00d", wb_mem_data_o);
        end
        stall_i = 1'b1; flush_i = 1'b1;
        ld(3'b010, 32'h0, 5'd7);
        checks++;
        if ({wb_valid_o, wb_reg_write_o, wb_fault_o, wb_sel_o} !== {3'b000, WB_NONE}) begin
            failures++;
            $display("FAIL stall_flush got v=%b rw=%b f=%b sel=%0d exp v=0 rw=0 f=0 sel=3",
                     wb_valid_o, wb_reg_write_o, wb_fault_o, wb_sel_o);
        end
        stall_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_wrap;
        st(3'b010, 32'h1000, 32'h1234_5678);
        ld(3'b010, 32'h0, 5'd10);
        checks++;
        if (wb_mem_data_o !== 32'h1234_5678) begin
            failures++; $display("FAIL addr_wrap got=%h exp=12345678", wb_mem_data_o);
        end
    endtask

    task automatic test_reset_mid_store;
        st(3'b010, 32'h300, 32'h0102_0304);
        ld(3'b010, 32'h300, 5'd11);
        rst = 1'b1;
        st(3'b010, 32'h300, 32'hFFFF_FFFF);
        checks++;
        if ({wb_valid_o, wb_reg_write_o, wb_fault_o, wb_rd_addr_o, wb_sel_o, wb_mem_data_o} !== {3'b000, 5'd0, WB_NONE, 32'd0}) begin
            failures++;
            $display("FAIL rst_mid got v=%b rw=%b f=%b rd=%0d sel=%0d d=%h exp zeros sel=3",
                     wb_valid_o, wb_reg_write_o, wb_fault_o, wb_rd_addr_o, wb_sel_o, wb_mem_data_o);
        end
        rst = 1'b0;
        ld(3'b010, 32'h300, 5'd11);
        checks++;
        if (wb_mem_data_o !== 32'h0102_0304) begin
            failures++; $display("FAIL rst_no_write got=%h exp=01020304", wb_mem_data_o);
        end
        ex_pc_plus4_i = 32'h0000_0044;
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0060, 32'd0, 5'd1, 1'b1, WB_PC4);
        checks++;
        if ({wb_pc_plus4_o, wb_sel_o, wb_reg_write_o, wb_rd_addr_o, wb_alu_result_o, wb_mem_data_o}
            !== {32'h44, WB_PC4, 1'b1, 5'd1, 32'h60, 32'd0}) begin
            failures++;
            $display("FAIL jal_pc4 got pc4=%h sel=%0d rw=%b rd=%0d alu=%h d=%h exp pc4=44 sel=2 rw=1 rd=1 alu=60 d=0",
                     wb_pc_plus4_o, wb_sel_o, wb_reg_write_o, wb_rd_addr_o, wb_alu_result_o, wb_mem_data_o);
        end
    endtask

    initial begin
        test_reset;
        test_sw_lw;
        test_byte;
        test_half;
        test_stall_flush;
        test_wrap;
        test_reset_mid_store;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline: sits between the EX/MEM register (upstream) and writeback (downstream).
- Owns the word-organised data memory and performs byte/half/word stores with byte enables.
- Registers the MEM/WB pipeline fields and formats load data (sign/zero extension) for writeback.
- Supports stall, flush and misalignment/illegal-access flagging.

Parameters:
- DATA_WIDTH, 32, datapath width.
- DATA_MEM_DEPTH, 1024, number of 32-bit words in data memory.
- DATA_MEM_ADDR_WIDTH, $clog2(DATA_MEM_DEPTH), word-index width.
- ADDR_WIDTH, 5, register-file address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  hold the MEM/WB register; suppress the memory write.
- flush_i  in  1  kill the incoming instruction; insert a bubble.
- ex_valid_i  in  1  EX/MEM entry valid.
- ex_mem_read_i  in  1  load.
- ex_mem_write_i  in  1  store.
- ex_funct3_i  in  3  load/store width code (FUNCT3_LB/LH/LW/LBU/LHU/LWU, SB/SH/SW).
- ex_alu_result_i  in  32  byte address for load/store; ALU result otherwise.
- ex_store_data_i  in  32  rs2 value to store.
- ex_pc_plus4_i  in  32  PC+4 for jal/jalr writeback.
- ex_rd_addr_i  in  ADDR_WIDTH  destination register.
- ex_reg_write_i  in  1  writeback enable.
- ex_wb_sel_i  in  2  wb_sel_e (WB_ALU/WB_MEM/WB_PC4/WB_NONE).
- wb_valid_o  out  1  MEM/WB entry valid.
- wb_reg_write_o  out  1  gated writeback enable.
- wb_rd_addr_o  out  ADDR_WIDTH  destination register.
- wb_sel_o  out  2  wb_sel_e.
- wb_alu_result_o  out  32  registered ALU result.
- wb_pc_plus4_o  out  32  registered PC+4.
- wb_mem_data_o  out  32  formatted load data.
- wb_fault_o  out  1  misaligned or illegal-funct3 access occurred.

Behaviour:
- Reset (sync): all wb_* outputs 0; wb_sel_o = WB_NONE. Memory array is not reset; contents are undefined until written.
- Address decode:
  - word index = addr[DATA_MEM_ADDR_WIDTH+1:2]; lane = addr[1:0].
  - Upper address bits are ignored, so addresses wrap modulo 4*DATA_MEM_DEPTH bytes.
- Fault detection (access = ex_valid_i & (mem_read | mem_write)):
  - Misaligned: H/HU with lane[0]=1, or W/WU with lane != 0.
  - Illegal: store funct3 not in {SB, SH, SW}; load funct3 in {011, 111}.
  - FUNCT3_LWU (110) is treated as LW.
- Store:
  - we = ex_valid_i & ex_mem_write_i & ~fault & ~stall_i & ~flush_i.
  - Byte enables: SB -> 1 lane; SH -> lanes {0,1} or {2,3}; SW -> all four.
  - Store data is replicated into lanes (SB: byte x4; SH: half x2).
  - Write commits at the rising edge; only enabled bytes change.
- Load: synchronous read.
  - Raw word register captures mem[word index] at the edge when ~stall_i.
  - funct3 and lane are captured alongside it.
  - wb_mem_data_o is formed combinationally from the registered raw word/lane/funct3:
    - LB/LBU: sign/zero-extend the selected byte.
    - LH/LHU: sign/zero-extend the selected half.
    - LW: the whole word.
  - On fault, or when the entry is not a load, wb_mem_data_o = 0.
- Ordering: a store at edge N is visible to a load sampled at edge N+1 (back-to-back store->load to the same address returns the new data).
- Latency: one cycle, EX/MEM inputs -> wb_* outputs.
- Pipeline register update priority: rst > flush_i > stall_i > normal.
  - flush_i: wb_valid_o = 0, wb_reg_write_o = 0, wb_fault_o = 0, wb_sel_o = WB_NONE; other fields don't-care. flush_i wins over a simultaneous stall_i.
  - stall_i (no flush): every wb_* output and the raw word hold their values; no memory write.
  - Normal: capture inputs. wb_reg_write_o = ex_valid_i & ex_reg_write_i & ~fault; wb_fault_o = fault.
- ex_valid_i = 0: no memory write; wb_valid_o = 0, wb_reg_write_o = 0.
- Reset asserted mid-store: the write is suppressed in that cycle (rst overrides we).

Test Plan:
- SW 0xDEADBEEF @0x100, then LW @0x100 next cycle -> wb_mem_data_o = 0xDEADBEEF one cycle after the LW, wb_reg_write_o = 1.
- SB 0x80 @0x103 over 0x11223344; LB @0x103 -> 0xFFFFFF80; LBU -> 0x00000080; LW @0x100 -> 0x80223344.
- SH 0xBEEF @0x202, LH @0x202 -> 0xFFFFBEEF, LHU -> 0x0000BEEF; LH @0x201 -> wb_fault_o = 1, wb_reg_write_o = 0, data 0, no memory change.
- SW 0xAAAA5555 @0x0 with stall_i=1 -> memory unchanged (a later LW returns the prior value) and wb_* hold; stall_i+flush_i together -> wb_valid_o = 0.
- Address wrap: SW 0x12345678 @0x1000 then LW @0x0 -> 0x12345678.
- rst pulse mid-stream during a SW -> all wb_* = 0, wb_sel_o = WB_NONE, target word unchanged; jal entry (WB_PC4, pc+4 = 0x44) -> wb_pc_plus4_o = 0x44.
